// File: rtl/ftrace_event_buffer.sv
// rtl/ftrace_event_buffer.sv - commit-stream call/return/tail classifier feeding a circular trace buffer
module ftrace_event_buffer #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          commit_valid,
    input  logic [31:0]   commit_pc,
    input  logic [31:0]   commit_inst,
    input  logic [31:0]   commit_dnpc,
    input  logic          flush,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [1:0]    ev_type,
    output logic [31:0]   ev_pc,
    output logic [31:0]   ev_target,
    output logic [DW-1:0] ev_depth,
    output logic          buf_full,
    output logic [15:0]   drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] EV_NONE = 2'b00;
    localparam logic [1:0] EV_CALL = 2'b01;
    localparam logic [1:0] EV_RET  = 2'b10;
    localparam logic [1:0] EV_TAIL = 2'b11;

    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [2:0]    funct3;
    logic          is_jal;
    logic          is_jalr;
    logic          is_ret_inst;
    logic          ev_call;
    logic          ev_ret;
    logic          ev_tail;
    logic          ev_any;
    logic [1:0]    ev_code;

    logic [DW-1:0] depth;
    logic [DW-1:0] depth_next;
    logic [DW-1:0] depth_dec;
    logic [DW-1:0] stamp;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    logic [1:0]    mem_type   [DEPTH];
    logic [31:0]   mem_pc     [DEPTH];
    logic [31:0]   mem_target [DEPTH];
    logic [DW-1:0] mem_depth  [DEPTH];

    assign opcode      = commit_inst[6:0];
    assign rd          = commit_inst[11:7];
    assign funct3      = commit_inst[14:12];
    assign is_jal      = (opcode == 7'b1101111);
    assign is_jalr     = (opcode == 7'b1100111) && (funct3 == 3'b000);
    assign is_ret_inst = (commit_inst == 32'h0000_8067);

    assign ev_call = commit_valid && (is_jal || is_jalr) && (rd == 5'd1);
    assign ev_ret  = commit_valid && is_ret_inst;
    assign ev_tail = commit_valid && is_jalr && (rd == 5'd0)
                     && (commit_inst[31:20] == 12'd0) && !is_ret_inst;
    assign ev_any  = ev_call || ev_ret || ev_tail;

    always_comb begin
        ev_code = EV_NONE;
        if (ev_call)      ev_code = EV_CALL;
        else if (ev_ret)  ev_code = EV_RET;
        else if (ev_tail) ev_code = EV_TAIL;
    end

    assign depth_dec = (depth == '0) ? depth : depth - 1'b1;

    always_comb begin
        depth_next = depth;
        if (ev_call && (depth != '1)) depth_next = depth + 1'b1;
        else if (ev_ret)              depth_next = depth_dec;
    end

    // Returns carry the post-decrement depth so they match their call's stamp.
    assign stamp = ev_ret ? depth_dec : depth;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

    assign pop  = !empty && ev_ready;
    assign push = ev_any && (!full || pop);
    assign drop = ev_any && full && !pop;

    assign ev_valid  = !empty;
    assign ev_type   = empty ? EV_NONE : mem_type[rd_idx];
    assign ev_pc     = empty ? 32'd0   : mem_pc[rd_idx];
    assign ev_target = empty ? 32'd0   : mem_target[rd_idx];
    assign ev_depth  = empty ? '0      : mem_depth[rd_idx];
    assign buf_full  = full;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            depth    <= '0;
            drop_cnt <= 16'd0;
        end else begin
            depth <= depth_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Storage carries no reset; only entries between the pointers are ever visible.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem_type[wr_idx]   <= ev_code;
            mem_pc[wr_idx]     <= commit_pc;
            mem_target[wr_idx] <= commit_dnpc;
            mem_depth[wr_idx]  <= stamp;
        end
    end

endmodule

// File: tb/tb_ftrace_event_buffer.sv
// tb/tb_ftrace_event_buffer.sv - directed-vector bench for ftrace_event_buffer
module tb_ftrace_event_buffer;

    localparam logic [31:0] JAL_RA   = 32'h0080_00EF;
    localparam logic [31:0] JALR_RA  = 32'h0007_80E7;
    localparam logic [31:0] RET      = 32'h0000_8067;
    localparam logic [31:0] TAIL     = 32'h0007_8067;
    localparam logic [31:0] JAL_X0   = 32'h0000_006F;
    localparam logic [31:0] JALR_F3  = 32'h0007_90E7;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic [31:0] commit_dnpc;
    logic        flush;
    logic        ev_valid;
    logic        ev_ready;
    logic [1:0]  ev_type;
    logic [31:0] ev_pc;
    logic [31:0] ev_target;
    logic [7:0]  ev_depth;
    logic        buf_full;
    logic [15:0] drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    ftrace_event_buffer #(.DEPTH(16), .DW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .commit_dnpc  (commit_dnpc),
        .flush        (flush),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_type      (ev_type),
        .ev_pc        (ev_pc),
        .ev_target    (ev_target),
        .ev_depth     (ev_depth),
        .buf_full     (buf_full),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic rdy, input logic fl, input logic rs);
        commit_valid = v;
        commit_inst  = inst;
        commit_pc    = pc;
        commit_dnpc  = pc + 32'd8;
        ev_ready     = rdy;
        flush        = fl;
        rst          = rs;
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
        commit_inst  = 32'd0;
        ev_ready     = 1'b0;
        flush        = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic ev(input logic [31:0] inst, input logic [31:0] pc);
        step(1'b1, inst, pc, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_pop(input string tag, input logic [1:0] typ, input logic [7:0] dep);
        check({tag, "_valid"}, ev_valid, 1'b1);
        check({tag, "_type"}, ev_type, typ);
        check({tag, "_depth"}, ev_depth, dep);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, ev_valid, 1'b0);
        check({tag, "_type"}, ev_type, 2'b00);
        check({tag, "_pc"}, ev_pc, 32'd0);
        check({tag, "_target"}, ev_target, 32'd0);
        check({tag, "_depth"}, ev_depth, 8'd0);
        check({tag, "_full"}, buf_full, 1'b0);
        check({tag, "_drop"}, drop_cnt, 16'd0);
    endtask

    initial begin
        int cnt;
        logic [7:0] last;
        commit_valid = 0; commit_inst = 0; commit_pc = 0; commit_dnpc = 0;
        ev_ready = 0; flush = 0; rst = 1;
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        check_zero("reset");

        // single call then return
        commit_valid = 1; commit_inst = JAL_RA; commit_pc = 32'h8000_0000; commit_dnpc = 32'h8000_0008;
        @(posedge clk); #1; commit_valid = 0;
        check("call_valid", ev_valid, 1'b1);
        check("call_type", ev_type, 2'b01);
        check("call_pc", ev_pc, 32'h8000_0000);
        check("call_target", ev_target, 32'h8000_0008);
        check("call_depth", ev_depth, 8'd0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("call_popped", ev_valid, 1'b0);
        ev(RET, 32'h8000_0010);
        check("ret_pc", ev_pc, 32'h8000_0010);
        check("ret_target", ev_target, 32'h8000_0018);
        expect_pop("ret", 2'b10, 8'd0);
        check("ret_empty", ev_valid, 1'b0);

        // nesting plus an extra return at depth 0
        for (int i = 0; i < 3; i++) ev(JALR_RA, 32'h100 + i * 4);
        for (int i = 0; i < 4; i++) ev(RET, 32'h200 + i * 4);
        expect_pop("nest_c0", 2'b01, 8'd0);
        expect_pop("nest_c1", 2'b01, 8'd1);
        expect_pop("nest_c2", 2'b01, 8'd2);
        expect_pop("nest_r2", 2'b10, 8'd2);
        expect_pop("nest_r1", 2'b10, 8'd1);
        expect_pop("nest_r0", 2'b10, 8'd0);
        expect_pop("nest_rx", 2'b10, 8'd0);
        check("nest_empty", ev_valid, 1'b0);

        // classification
        ev(JAL_RA, 32'h300);
        ev(TAIL, 32'h304);
        ev(JAL_X0, 32'h308);
        ev(JALR_F3, 32'h30c);
        step(1'b0, JAL_RA, 32'h310, 1'b0, 1'b0, 1'b0);
        ev(RET, 32'h314);
        expect_pop("cls_call", 2'b01, 8'd0);
        check("cls_tail_pc", ev_pc, 32'h304);
        expect_pop("cls_tail", 2'b11, 8'd1);
        check("cls_ret_pc", ev_pc, 32'h314);
        expect_pop("cls_ret", 2'b10, 8'd0);
        check("cls_empty", ev_valid, 1'b0);

        // overflow with ev_ready low
        for (int i = 0; i < 20; i++) begin
            ev(JAL_RA, 32'h400 + i * 4);
            if (i == 14) check("ovf_not_full15", buf_full, 1'b0);
            if (i == 15) check("ovf_full16", buf_full, 1'b1);
            if (i == 15) check("ovf_drop16", drop_cnt, 16'd0);
        end
        check("ovf_drop", drop_cnt, 16'd4);
        for (int i = 0; i < 16; i++) expect_pop($sformatf("ovf_e%0d", i), 2'b01, 8'(i));
        check("ovf_empty", ev_valid, 1'b0);
        check("ovf_full_clr", buf_full, 1'b0);
        ev(RET, 32'h500);
        expect_pop("ovf_depth20", 2'b10, 8'd19);

        // full with simultaneous push and pop: depth is 19
        for (int i = 0; i < 16; i++) ev(JAL_RA, 32'h600 + i * 4);
        check("pp_full_before", buf_full, 1'b1);
        step(1'b1, JAL_RA, 32'h700, 1'b1, 1'b0, 1'b0);
        check("pp_full_after", buf_full, 1'b1);
        check("pp_drop", drop_cnt, 16'd4);
        check("pp_head", ev_depth, 8'd20);
        cnt = 0; last = 0;
        for (int i = 0; i < 20 && ev_valid; i++) begin
            last = ev_depth;
            cnt++;
            step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        end
        check("pp_count", cnt, 16);
        check("pp_last", last, 8'd35);

        // flush: depth is 36
        for (int i = 0; i < 5; i++) ev(JAL_RA, 32'h800 + i * 4);
        check("fl_pre", ev_valid, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        check("fl_valid", ev_valid, 1'b0);
        check("fl_drop", drop_cnt, 16'd4);
        ev(RET, 32'h900);
        expect_pop("fl_depth", 2'b10, 8'd40);
        step(1'b1, JAL_RA, 32'h904, 1'b0, 1'b1, 1'b0);
        check("fl_evt_valid", ev_valid, 1'b0);
        ev(RET, 32'h908);
        expect_pop("fl_evt_depth", 2'b10, 8'd40);

        // reset mid-stream
        for (int i = 0; i < 3; i++) ev(JAL_RA, 32'hA00 + i * 4);
        step(1'b1, JAL_RA, 32'hA0C, 1'b1, 1'b0, 1'b1);
        check_zero("rst_mid");
        ev(JAL_RA, 32'hB00);
        check("rst_call_pc", ev_pc, 32'hB00);
        expect_pop("rst_call", 2'b01, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
